adc_sampler_spi: RTL and testbench

- Upstream acquisition stage for the averaging chain.
- Periodically reads one conversion from an external SPI ADC (mode 0, MSB first; MCP3201-class framing).
- Presents the result on sample_value with a one-clock trigger pulse, wired directly to the averagers' sample_value/trigger inputs.
- Owns ADC timing: chip select, serial clock generation, sample-rate pacing.

---
 rtl/adc_sampler_spi.sv | 90 +++++++++
 tb/tb_adc_sampler_spi.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adc_sampler_spi.sv
// adc_sampler_spi: paced SPI ADC reader (mode 0, MSB first) feeding sample_value/trigger.
// Optional sticky overrun output when ADC_SAMPLER_OVERRUN_EN is defined.
module adc_sampler_spi #(
  parameter int bitwidth_sample = 12,
  parameter int leading_bits = 3,
  parameter int clock_divider = 2,
  parameter int sample_interval = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       adc_miso,
  output logic                       adc_cs_n,
  output logic                       adc_sclk,
  output logic [bitwidth_sample-1:0] sample_value,
  output logic                       trigger,
  output logic                       busy
`ifdef ADC_SAMPLER_OVERRUN_EN
  ,
  output logic                       overrun
`endif
);
  localparam int n_bits = leading_bits + bitwidth_sample;
  localparam int iw = $clog2(sample_interval);
  localparam int dw = clock_divider > 1 ? $clog2(clock_divider) : 1;
  localparam int bw = $clog2(n_bits + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  state_t state;
  logic [iw-1:0] interval_cnt;
  logic [dw-1:0] div_cnt;
  logic [bw-1:0] bit_cnt;
  logic [bitwidth_sample-1:0] shreg;
  logic tick, accept, div_end, keep_bit;
  always_comb begin
    tick = enable && interval_cnt == '0;
    accept = tick && !busy;
    div_end = div_cnt == dw'(clock_divider - 1);
    keep_bit = bit_cnt >= bw'(leading_bits);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) interval_cnt <= '0;
    else interval_cnt <= !enable || interval_cnt == iw'(sample_interval - 1) ? '0 : interval_cnt + 1'b1;
  // SETUP is the SHIFT datapath with sclk still low, so both share one branch.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      sample_value <= '0;
      trigger <= 1'b0;
      busy <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
    end else begin
      trigger <= 1'b0;
      case (state)
        IDLE, DONE:
          if (accept) begin
            state <= SETUP;
            adc_cs_n <= 1'b0;
            busy <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
          end else state <= IDLE;
        SETUP, SHIFT:
          if (!div_end) div_cnt <= div_cnt + 1'b1;
          else begin
            div_cnt <= '0;
            adc_sclk <= !adc_sclk;
            if (!adc_sclk) begin
              state <= SHIFT;
              if (keep_bit) shreg <= bitwidth_sample'({shreg, adc_miso});
            end else if (bit_cnt == bw'(n_bits - 1)) begin
              state <= DONE;
              adc_cs_n <= 1'b1;
              busy <= 1'b0;
              trigger <= 1'b1;
              sample_value <= shreg;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
      endcase
    end
`ifdef ADC_SAMPLER_OVERRUN_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) overrun <= 1'b0;
    else if (tick && busy) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_adc_sampler_spi.sv
// tb_adc_sampler_spi: randomized checks of two sampler instances against a tick/latency model.
module tb_adc_sampler_spi;
  localparam int lat = 2 * 2 * 15;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset [2], enable [2], miso [2], cs_n [2], sclk [2], trigger [2], busy [2];
  logic [11:0] sample [2];
  logic [14:0] frame [2];
  int idx [2];
  logic prev_sclk [2];
  int cyc = 0;
  int checks = 0, errors = 0;
`ifdef ADC_SAMPLER_OVERRUN_EN
  logic overrun [2];
`endif
  adc_sampler_spi u_dut (
    .clock(clock), .reset(reset[0]), .enable(enable[0]), .adc_miso(miso[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample_value(sample[0]),
    .trigger(trigger[0]), .busy(busy[0])
`ifdef ADC_SAMPLER_OVERRUN_EN
    , .overrun(overrun[0])
`endif
  );
  adc_sampler_spi #(.sample_interval(40)) u_ovr (
    .clock(clock), .reset(reset[1]), .enable(enable[1]), .adc_miso(miso[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample_value(sample[1]),
    .trigger(trigger[1]), .busy(busy[1])
`ifdef ADC_SAMPLER_OVERRUN_EN
    , .overrun(overrun[1])
`endif
  );
  always @(posedge clock) cyc++;
  // ADC model: frame bit 14 valid at CS fall, next bit after each SCLK fall.
  always @(negedge clock)
    for (int u = 0; u < 2; u++) begin
      if (cs_n[u]) idx[u] = 0;
      else if (prev_sclk[u] && !sclk[u]) idx[u]++;
      prev_sclk[u] = sclk[u];
      miso[u] = idx[u] < 15 ? frame[u][14-idx[u]] : 1'b0;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input int u, input string tag);
    check({tag, "_cs_n"}, 32'(cs_n[u]), 1);
    check({tag, "_sclk"}, 32'(sclk[u]), 0);
    check({tag, "_value"}, 32'(sample[u]), 0);
    check({tag, "_trigger"}, 32'(trigger[u]), 0);
    check({tag, "_busy"}, 32'(busy[u]), 0);
  endtask
  task automatic start(input int u, input logic [11:0] data, input logic [2:0] lead);
    frame[u] = {lead, data};
    @(negedge clock) enable[u] = 1'b1;
    @(negedge clock) enable[u] = 1'b0;
    check("cs_fall", 32'(cs_n[u]), 0);
  endtask
  task automatic run_conv(input int u, input logic [11:0] data, input logic [2:0] lead, input string tag);
    int n, edges;
    logic ps;
    start(u, data, lead);
    n = 0;
    edges = 0;
    ps = sclk[u];
    while (!trigger[u] && n < 200) begin
      @(negedge clock);
      n++;
      if (sclk[u] && !ps) edges++;
      ps = sclk[u];
    end
    check({tag, "_latency"}, 32'(n), lat);
    check({tag, "_edges"}, 32'(edges), 15);
    check({tag, "_value"}, 32'(sample[u]), 32'(data));
    check({tag, "_cs_done"}, 32'(cs_n[u]), 1);
    check({tag, "_busy_done"}, 32'(busy[u]), 0);
    @(negedge clock);
    check({tag, "_pulse"}, 32'(trigger[u]), 0);
  endtask
  // Enable for 500 clocks; model accepts a tick only once the prior conversion's busy window is over.
  task automatic pace(input int u, input int interval, input logic [11:0] data, input string tag);
    int exp_q[$], obs_q[$];
    int last, skip, cx;
    last = -1000;
    skip = -1;
    for (int t = 0; t < 500; t += interval)
      if (t > last + lat) begin
        exp_q.push_back(t + lat + 1);
        last = t;
      end else if (skip < 0) skip = t;
    frame[u] = {3'($urandom), data};
    @(negedge clock) enable[u] = 1'b1;
    cx = cyc;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (i == 499) enable[u] = 1'b0;
      if (trigger[u]) begin
        obs_q.push_back(cyc - cx);
        check({tag, "_value"}, 32'(sample[u]), 32'(data));
      end
`ifdef ADC_SAMPLER_OVERRUN_EN
      if (i + 1 == skip) check({tag, "_ovr_pre"}, 32'(overrun[u]), 0);
      if (i + 1 == skip + 1) check({tag, "_ovr_set"}, 32'(overrun[u]), 1);
`endif
    end
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_time"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_idle_busy"}, 32'(busy[u]), 0);
`ifdef ADC_SAMPLER_OVERRUN_EN
    check({tag, "_ovr_end"}, 32'(overrun[u]), skip >= 0 ? 1 : 0);
`endif
  endtask
  initial begin
    reset = '{1'b1, 1'b1};
    enable = '{1'b0, 1'b0};
    frame = '{15'h0, 15'h0};
    repeat (3) @(negedge clock);
    check_reset(0, "rst_init");
    check_reset(1, "rst_init1");
    reset = '{1'b0, 1'b0};
    repeat (5) @(negedge clock);
    run_conv(0, 12'hA5C, 3'($urandom), "basic");
    run_conv(0, 12'h001, 3'b111, "lead");
    for (int i = 0; i < 6; i++) run_conv(0, 12'($urandom), 3'($urandom), "rand");
    reset[0] = 1'b1;
    #1 check_reset(0, "rst_idle");
    @(negedge clock) reset[0] = 1'b0;
    @(negedge clock);
    pace(0, 100, 12'h7FF, "pace");
    pace(1, 40, 12'($urandom), "ovr");
`ifdef ADC_SAMPLER_OVERRUN_EN
    reset[1] = 1'b1;
    #1 check("ovr_clear", 32'(overrun[1]), 0);
    @(negedge clock) reset[1] = 1'b0;
`endif
    run_conv(0, 12'h5A5, 3'($urandom), "pre_abort");
    start(0, 12'hFFF, 3'b111);
    repeat (30) @(negedge clock);
    check("abort_busy_before", 32'(busy[0]), 1);
    reset[0] = 1'b1;
    #1 check_reset(0, "abort");
    @(negedge clock);
    @(negedge clock) reset[0] = 1'b0;
    @(negedge clock);
    run_conv(0, 12'h3C3, 3'($urandom), "post_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
